// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker: pops show-ahead FIFO words and emits them LSB-first as RATIO beats; FIFO_UNPACK_STALL_COUNT_EN adds stall_count
`timescale 1ns/1ps
module fifo_word_unpacker #(
  parameter int OUT_WIDTH = 8,
  parameter int RATIO = 4,
  parameter int WIDTH = OUT_WIDTH*RATIO,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_q,
  output logic                 fifo_rdreq,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last
`ifdef FIFO_UNPACK_STALL_COUNT_EN
  , output logic [CNT_WIDTH-1:0] stall_count
`endif
);
  localparam int BW = RATIO > 1 ? $clog2(RATIO) : 1;
  if (RATIO < 1 || WIDTH != OUT_WIDTH*RATIO || CNT_WIDTH < 1) begin : g_bad_params
    $error("fifo_word_unpacker: WIDTH must equal OUT_WIDTH*RATIO with RATIO >= 1");
  end
  logic [RATIO-1:0][OUT_WIDTH-1:0] r_word;
  logic [BW-1:0] r_beat;
  logic r_loaded;
  logic w_xfer;
  assign out_valid = r_loaded;
  assign out_data = r_word[r_beat];
  assign out_last = r_loaded && r_beat == BW'(RATIO-1);
  assign w_xfer = out_valid && out_ready;
  // last-beat transfer and next pop share a cycle, so words stream without bubbles
  assign fifo_rdreq = !rst && !fifo_empty && (!r_loaded || (out_ready && out_last));
  always_ff @(posedge clock) begin
    if (rst) begin
      r_loaded <= 1'b0;
      r_beat <= '0;
    end else if (fifo_rdreq) begin
      r_word <= fifo_q;
      r_beat <= '0;
      r_loaded <= 1'b1;
    end else if (w_xfer && out_last) begin
      r_loaded <= 1'b0;
      r_beat <= '0;
    end else if (w_xfer) begin
      r_beat <= r_beat + 1'b1;
    end
  end
`ifdef FIFO_UNPACK_STALL_COUNT_EN
  logic [CNT_WIDTH-1:0] r_stall;
  always_ff @(posedge clock) begin
    if (rst) r_stall <= '0;
    else if (out_valid && !out_ready && !(&r_stall)) r_stall <= r_stall + 1'b1;
  end
  assign stall_count = r_stall;
`endif
`ifndef NO_DYNAMIC_ASSERTS
  a_no_pop_empty: assert property (@(posedge clock) disable iff (rst) !(fifo_rdreq && fifo_empty));
  a_stall_stable: assert property (@(posedge clock) disable iff (rst)
    out_valid && !out_ready |=> out_valid && $stable(out_data) && $stable(out_last));
`endif
endmodule

// File: doc/fifo_word_unpacker.md
Name: fifo_word_unpacker

Overview:
- Downstream consumer of the register skid FIFO: pops one wide FIFO word and emits it as RATIO narrow beats on a valid/ready stream.
- Sits between a wide-datapath FIFO and a narrow downstream port, e.g. a serialiser or narrow memory write path.
- Drives the FIFO's rdreq/empty/q side directly. The FIFO's q is valid whenever empty is low (show-ahead).

Parameters:
- OUT_WIDTH, 8, width of one output beat in bits.
- RATIO, 4, output beats per FIFO word; must be >= 1.
- WIDTH, OUT_WIDTH*RATIO, FIFO word width; elaboration error if WIDTH != OUT_WIDTH*RATIO.
- CNT_WIDTH, 16, stall counter width; used only with the optional feature.

Ports:
- clock  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_q  input  WIDTH  FIFO head word; valid when fifo_empty=0.
- fifo_rdreq  output  1  pop FIFO head this cycle.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  OUT_WIDTH  current beat.
- out_last  output  1  current beat is the final beat of its word.
- stall_count  output  CNT_WIDTH  present only with FIFO_UNPACK_STALL_COUNT_EN.

Behaviour:
- State:
  - word_ff (WIDTH): held word.
  - beat_ff: index, $clog2(RATIO) bits, minimum 1 bit.
  - loaded_ff: word held.
- Beat order: LSB first. Beat i is word_ff[i*OUT_WIDTH +: OUT_WIDTH].
- Outputs:
  - out_valid = loaded_ff.
  - out_data = slice selected by beat_ff.
  - out_last = loaded_ff && (beat_ff == RATIO-1).
- Handshake: a beat transfers when out_valid && out_ready. out_data and out_last are stable while out_valid && !out_ready. out_valid never drops without a transfer.
- fifo_rdreq is combinational:
  - fifo_rdreq = !rst && !fifo_empty && (!loaded_ff || (out_ready && out_last)).
  - It is never asserted when fifo_empty=1.
- On fifo_rdreq: word_ff <= fifo_q, beat_ff <= 0, loaded_ff <= 1. This takes priority over the clear below.
- Transfer of a non-last beat: beat_ff <= beat_ff+1.
- Transfer of the last beat without fifo_rdreq: loaded_ff <= 0, beat_ff <= 0.
- Latency: a word at the FIFO head while idle gives out_valid on the next cycle.
- Throughput: one beat per cycle sustained while the FIFO is non-empty and out_ready=1. No bubble between words, because the last beat and the next pop overlap in the same cycle.
- RATIO=1: out_last=1 whenever out_valid. The block degenerates to a pass-through register with back-to-back pops.
- Reset:
  - loaded_ff=0, beat_ff=0, so out_valid=0, out_last=0, fifo_rdreq=0.
  - out_data is don't-care while out_valid=0.
  - Reset mid-word discards the remaining beats. The FIFO is not popped during rst.
- Simultaneous fifo_empty=0 and last-beat transfer: pop and reload in the same cycle; beat_ff returns to 0.
- A last beat stalled (out_ready=0) blocks the pop even if the FIFO is non-empty.
- Dynamic asserts (unless NO_DYNAMIC_ASSERTS):
  - no fifo_rdreq while fifo_empty;
  - out_data is stable during stall.

Optional Feature:
- Macro: FIFO_UNPACK_STALL_COUNT_EN.
- Defined:
  - stall_count port exists. It is a saturating counter of cycles with out_valid && !out_ready.
  - Reset value 0. It holds at 2^CNT_WIDTH-1 once saturated.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then one word 0xDDCCBBAA with RATIO=4 and out_ready=1 → fifo_rdreq pulses once. Beats 0xAA, 0xBB, 0xCC, 0xDD appear on consecutive cycles starting 1 cycle after the pop; out_last only on 0xDD.
- FIFO holds 3 words, out_ready=1 → 12 contiguous beats with out_valid never low. fifo_rdreq asserts in the same cycle as each out_last transfer.
- Same word, out_ready low for 5 cycles on beat 0xBB → out_data stays 0xBB and beat_ff stays 1. No pop occurs even with the FIFO non-empty. With the macro defined, stall_count=5.
- Assert rst during beat 2 of 0x44332211 → next cycle out_valid=0 and fifo_rdreq=0. After release, the next FIFO word starts at beat 0; remaining beats 0x33 and 0x44 are never emitted.
- RATIO=1, OUT_WIDTH=32, FIFO words 1, 2, 3, out_ready=1 → out_data 1, 2, 3 on consecutive cycles, out_last=1 each cycle. fifo_empty=1 leads to out_valid=0 one cycle later.
- CNT_WIDTH=4 with the macro defined, out_ready=0 for 20 cycles with out_valid=1 → stall_count saturates at 15 and holds.
